// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: processes WIDTH-bit operands SLICE bits per clock through one narrow adder,
// with an internal architectural carry flag for ADC/SBB chains.
module alu_multicycle #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clc,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             c_flag,
  output logic             z_flag,
  output logic             v_flag
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q, res_q, y_q;
  logic [2:0]         op_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               c_q, z_q, v_q;

  logic               arith, last, cout, cout_1;
  logic [SLICE:0]     sum;
  logic [SLICE-1:0]   logic_sl, slice_res;
  logic [WIDTH-1:0]   res_next;

  assign arith = ~op_q[2];
  assign last  = (cnt_q == CNT_W'(NSLICE - 1));

  // Operands shift right each cycle, so the active slice is always the low SLICE bits.
  always_comb begin
    sum = {1'b0, a_q[SLICE-1:0]} + {1'b0, b_q[SLICE-1:0]} + {{SLICE{1'b0}}, carry_q};
    logic_sl = '0;
    unique case (op_q[1:0])
      2'b00:   logic_sl = a_q[SLICE-1:0] & b_q[SLICE-1:0];
      2'b01:   logic_sl = a_q[SLICE-1:0] | b_q[SLICE-1:0];
      2'b10:   logic_sl = a_q[SLICE-1:0] ^ b_q[SLICE-1:0];
      default: logic_sl = b_q[SLICE-1:0];
    endcase
    slice_res = arith ? sum[SLICE-1:0] : logic_sl;
    cout      = sum[SLICE];
    // Carry into the slice MSB recovered from the sum bit.
    cout_1    = a_q[SLICE-1] ^ b_q[SLICE-1] ^ sum[SLICE-1];
    res_next  = (res_q >> SLICE) | (WIDTH'(slice_res) << (WIDTH - SLICE));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      y_q     <= '0;
      op_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      v_q     <= 1'b0;
    end else if (state_q == StIdle) begin
      if (clc) c_q <= 1'b0;
      if (start) begin
        a_q     <= a;
        b_q     <= (~op[2] & op[1]) ? ~b : b;
        op_q    <= op;
        // clc on the accept edge takes effect before ADC/SBB read the flag.
        carry_q <= op[0] ? (c_q & ~clc) : op[1];
        cnt_q   <= '0;
      end
    end else if (state_q == StRun) begin
      a_q     <= a_q >> SLICE;
      b_q     <= b_q >> SLICE;
      res_q   <= res_next;
      carry_q <= cout;
      cnt_q   <= cnt_q + CNT_W'(1);
      if (last) begin
        y_q <= res_next;
        z_q <= (res_next == '0);
        v_q <= arith & (cout ^ cout_1);
        if (arith) c_q <= cout;
      end
    end
  end

  assign ready  = (state_q == StIdle);
  assign done   = (state_q == StDone);
  assign y      = y_q;
  assign c_flag = c_q;
  assign z_flag = z_q;
  assign v_flag = v_q;

endmodule
